// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around an external registered-read RAM.
// A two-entry output buffer hides the read latency for FWFT pops.
module sync_fifo_ctrl #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             ram_wenc,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_renc,
    output logic [AW-1:0]    ram_raddr,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [AW+1:0]    count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic [AW:0]      ram_cnt;
    logic [1:0]       occ_pop;
    logic             push;
    logic             pop;
    logic             issue;

    always_comb begin
        ram_cnt = wptr_q - rptr_q;
        s_ready = !rst && (ram_cnt != FULL);
        push    = s_valid && s_ready;
        m_valid = !rst && (occ_q != 2'd0);
        pop     = m_valid && m_ready;
        occ_pop = occ_q - {1'b0, pop};
        // Only issue a read if the buffer can absorb it after this pop.
        issue   = !rst && (ram_cnt != '0)
                  && (({1'b0, occ_pop} + {2'b0, inflight_q}) < 3'd2);
    end

    always_comb begin
        ram_wenc  = push;
        ram_waddr = rst ? '0 : wptr_q[AW-1:0];
        ram_wdata = s_data;
        ram_renc  = issue;
        ram_raddr = rst ? '0 : rptr_q[AW-1:0];
        m_data    = rst ? '0 : head_q;
        count     = rst ? '0 : (AW+2)'(ram_cnt)
                               + (AW+2)'(inflight_q)
                               + (AW+2)'(occ_q);
    end

    always_comb begin
        wptr_d     = wptr_q + {{AW{1'b0}}, push};
        rptr_d     = rptr_q + {{AW{1'b0}}, issue};
        inflight_d = issue;
        head_d     = head_q;
        skid_d     = skid_q;
        if (pop && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end
        if (inflight_q) begin
            if (occ_pop == 2'd0) begin
                head_d = ram_rdata;
            end else begin
                skid_d = ram_rdata;
            end
        end
        occ_d = occ_pop + {1'b0, inflight_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue reference model, RAM model,
// scoreboard monitor on the pop side.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             ram_wenc;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_renc;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic [AW+1:0]    count;

    sync_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ram_wenc  (ram_wenc),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_renc  (ram_renc),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .count     (count)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (ram_wenc) mem[ram_waddr] <= ram_wdata;
        if (ram_renc) ram_rdata <= mem[ram_raddr];
    end

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q [$];
    int n_acc;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data;

    logic             smp_acc, smp_sr, smp_mv, smp_re;
    logic [WIDTH-1:0] smp_md;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: checks outputs and pops the expected queue on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_count", count, 0);
            chk("rst_wenc", ram_wenc, 0);
            chk("rst_renc", ram_renc, 0);
            chk("rst_waddr", ram_waddr, 0);
            chk("rst_raddr", ram_raddr, 0);
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            chk("count", count, exp_q.size());
            chk("count_max", (count <= DEPTH + 2), 1);
            chk("wenc", ram_wenc, (s_valid && s_ready));
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("pop_empty", 1, 0);
                else chk("pop_data", m_data, exp_q.pop_front());
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    // Driver: one clock of stimulus; accepted pushes go into the model queue.
    task automatic step(input logic sv, input logic [WIDTH-1:0] d, input logic mr);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        @(negedge clk);
        smp_acc = s_valid && s_ready;
        smp_sr  = s_ready;
        smp_mv  = m_valid;
        smp_re  = ram_renc;
        smp_md  = m_data;
        @(posedge clk);
        if (smp_acc) begin
            exp_q.push_back(d);
            n_acc++;
        end
        #1;
    endtask

    initial begin
        int k;
        int pushed;
        int popped;
        logic seen;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_rdata = '0;
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h11;
        m_ready = 1'b0;
        n_acc = 0;
        @(posedge clk); #1;
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        chk("rst_no_accept", n_acc, 0);
        rst = 1'b0;

        // single word latency
        step(1'b1, 8'hA5, 1'b1);
        chk("single_acc", smp_acc, 1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            step(1'b0, 8'h00, 1'b1);
            k++;
            if (smp_mv) seen = 1'b1;
        end
        chk("single_latency", k, 3);
        chk("single_data", smp_md, 8'hA5);
        step(1'b0, 8'h00, 1'b1);

        // fill under backpressure
        n_acc = 0;
        for (int i = 0; i < 30; i++) step(1'b1, WIDTH'(i), 1'b0);
        chk("fill_accepted", n_acc, DEPTH + 2);
        chk("fill_s_ready", smp_sr, 0);
        chk("fill_count", count, DEPTH + 2);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_valid", smp_mv, 1);
            if (i == 1) chk("drain_s_ready", smp_sr, 1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", smp_mv, 0);

        // streaming
        pushed = 0;
        popped = 0;
        seen = 1'b0;
        k = 0;
        while (popped < 100 && k < 300) begin
            step(pushed < 100, WIDTH'(8'h40 + pushed), 1'b1);
            if (smp_acc) pushed++;
            if (smp_mv) begin
                seen = 1'b1;
                popped++;
            end else if (seen) begin
                chk("stream_bubble", smp_mv, 1);
            end
            k++;
        end
        chk("stream_pops", popped, 100);
        chk("stream_cycles", (k <= 104), 1);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom % 2), WIDTH'($urandom), 1'($urandom % 2));
        end
        k = 0;
        while ((exp_q.size() != 0) && k < 60) begin
            step(1'b0, 8'h00, 1'b1);
            k++;
        end
        chk("random_drained", exp_q.size(), 0);

        // reset with a read in flight
        for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h90, 1'b1);
        chk("mid_issue", smp_re, 1);
        chk("mid_pre_count", count, 10);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        chk("mid_post_valid", smp_mv, 0);
        chk("mid_post_count", count, 0);
        step(1'b1, 8'h3C, 1'b1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            step(1'b0, 8'h00, 1'b1);
            k++;
            if (smp_mv) seen = 1'b1;
        end
        chk("mid_first_seen", seen, 1);
        chk("mid_first_data", smp_md, 8'h3C);
        step(1'b0, 8'h00, 1'b0);
        chk("final_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
